ysyx_24100012_load_unit: RTL and testbench

Multi-cycle load unit for the NPC core, the read-side counterpart of the partial store path. It sits between the execute stage and data memory. It accepts one load request per handshake and issues a word-aligned read over a req/gnt/rvalid bus. It then extracts the byte, halfword or word selected by addr[1:0] and func3, sign- or zero-extends it, and hands the result with its destination tag to writeback over a valid/ready interface.

---
 rtl/ysyx_24100012_load_unit_if.sv | 30 +++
 rtl/ysyx_24100012_load_unit.sv | 122 ++++++++++++
 tb/tb_ysyx_24100012_load_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100012_load_unit_if.sv
// ysyx_24100012_load_unit_if: request, dmem and writeback signals of the load unit
interface ysyx_24100012_load_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            func3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [4:0]            rd;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [4:0]            out_rd;
  logic                  out_fault;
  modport slave (
    input  in_valid, func3, addr, rd, mem_gnt, mem_rvalid, mem_rdata, mem_err, out_ready,
    output in_ready, mem_req, mem_addr, out_valid, out_data, out_rd, out_fault
  );
  modport master (
    output in_valid, func3, addr, rd, mem_gnt, mem_rvalid, mem_rdata, mem_err, out_ready,
    input  in_ready, mem_req, mem_addr, out_valid, out_data, out_rd, out_fault
  );
endinterface

// File: rtl/ysyx_24100012_load_unit.sv
// ysyx_24100012_load_unit: multi-cycle load with word-aligned dmem read, extraction and extension
module ysyx_24100012_load_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic rst,
  ysyx_24100012_load_unit_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e                state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [4:0]            out_rd_q, out_rd_d;
  logic                  out_fault_q, out_fault_d;
  logic                  bad;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [DATA_WIDTH-1:0] fmt;
  assign bus_io.in_ready  = (state_q == IDLE) & ~rst;
  assign bus_io.mem_req   = mem_req_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_rd    = out_rd_q;
  assign bus_io.out_fault = out_fault_q;
  // Request check at accept, and lane extraction/extension of the returned word
  always_comb begin
    bad = (bus_io.func3 == 3'b011) | (bus_io.func3[2:1] == 2'b11)
        | ((bus_io.func3[1:0] == 2'b01) & bus_io.addr[0])
        | ((bus_io.func3 == 3'b010) & (bus_io.addr[1:0] != 2'b00));
    byte_s = bus_io.mem_rdata[{off_q, 3'b000} +: 8];
    half_s = bus_io.mem_rdata[{off_q[1], 4'b0000} +: 16];
    fmt = f3_q == 3'b000 ? {{(DATA_WIDTH-8){byte_s[7]}}, byte_s}
        : f3_q == 3'b001 ? {{(DATA_WIDTH-16){half_s[15]}}, half_s}
        : f3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_s}
        : f3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_s}
        : bus_io.mem_rdata;
  end
  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_fault_d = out_fault_q;
    case (state_q)
      IDLE: if (bus_io.in_valid) begin
        f3_d        = bus_io.func3;
        off_d       = bus_io.addr[1:0];
        out_rd_d    = bus_io.rd;
        mem_addr_d  = {bus_io.addr[ADDR_WIDTH-1:2], 2'b00};
        out_data_d  = '0;
        out_fault_d = bad;
        out_valid_d = bad;
        mem_req_d   = ~bad;
        state_d     = bad ? RESP : REQ;
      end
      REQ: if (bus_io.mem_gnt) begin
        mem_req_d = 1'b0;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_io.mem_rvalid) begin
          out_valid_d = 1'b1;
          out_fault_d = bus_io.mem_err;
          out_data_d  = bus_io.mem_err ? '0 : fmt;
          state_d     = RESP;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          out_valid_d = 1'b1;
          out_fault_d = 1'b1;
          out_data_d  = '0;
          state_d     = RESP;
        end
      end
      RESP: if (bus_io.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_fault_q <= out_fault_d;
    end
  end
endmodule

// File: tb/tb_ysyx_24100012_load_unit.sv
// tb_ysyx_24100012_load_unit: vector table and scoreboard bench for the load unit
module tb_ysyx_24100012_load_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  ysyx_24100012_load_unit_if bus();
  ysyx_24100012_load_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .bus_io(bus.slave)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_d;
    logic        exp_f;
    logic        exp_mem;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
        chk("out_fault", {31'd0, bus.out_fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int gdly, input int hold);
    logic [31:0] ma;
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.func3     = v.f3;
    bus.addr      = v.a;
    bus.rd        = v.rd;
    bus.out_ready = (hold == 0);
    sb.push_back('{v.exp_d, v.rd, v.exp_f});
    tick();
    bus.in_valid = 1'b0;
    ma = {v.a[31:2], 2'b00};
    if (v.exp_mem) begin
      chk("mem_req_c1", {31'd0, bus.mem_req}, 32'd1);
      chk("mem_addr", bus.mem_addr, ma);
      for (int i = 0; i < gdly; i++) begin
        tick();
        chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
        chk("mem_addr_hold", bus.mem_addr, ma);
        chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.rdata;
      bus.mem_err    = v.err;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_err    = 1'b0;
    end else begin
      chk("no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end
    chk("out_valid_rise", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_data", bus.out_data, v.exp_d);
      chk("hold_rd", {27'd0, bus.out_rd}, {27'd0, v.rd});
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("out_valid_clear", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
  endtask

  vec_t tbl[14];
  int   n;

  initial begin
    tbl[0]  = '{3'b000, 32'h8000_0003, 5'd1,  32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1};
    tbl[1]  = '{3'b100, 32'h8000_0003, 5'd2,  32'h80FF_1234, 1'b0, 32'h0000_0080, 1'b0, 1'b1};
    tbl[2]  = '{3'b001, 32'h8000_0002, 5'd3,  32'h8001_7FFF, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1};
    tbl[3]  = '{3'b101, 32'h8000_0002, 5'd4,  32'h8001_7FFF, 1'b0, 32'h0000_8001, 1'b0, 1'b1};
    tbl[4]  = '{3'b010, 32'h8000_0000, 5'd5,  32'h8001_7FFF, 1'b0, 32'h8001_7FFF, 1'b0, 1'b1};
    tbl[5]  = '{3'b010, 32'h8000_0002, 5'd6,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
    tbl[6]  = '{3'b001, 32'h8000_0001, 5'd7,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
    tbl[7]  = '{3'b011, 32'h8000_0000, 5'd8,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
    tbl[8]  = '{3'b000, 32'h8000_0101, 5'd9,  32'h80FF_1234, 1'b0, 32'h0000_0012, 1'b0, 1'b1};
    tbl[9]  = '{3'b001, 32'h1000_0000, 5'd10, 32'h1234_ABCD, 1'b0, 32'hFFFF_ABCD, 1'b0, 1'b1};
    tbl[10] = '{3'b010, 32'h8000_0008, 5'd11, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b1, 1'b1};
    tbl[11] = '{3'b100, 32'h8000_0002, 5'd12, 32'h80FF_1234, 1'b0, 32'h0000_00FF, 1'b0, 1'b1};
    tbl[12] = '{3'b111, 32'h8000_0004, 5'd13, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
    tbl[13] = '{3'b101, 32'h8000_0003, 5'd14, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
    bus.in_valid   = 1'b0;
    bus.func3      = '0;
    bus.addr       = '0;
    bus.rd         = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_err    = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) run(tbl[i], 0, 0);
    run(tbl[2], 4, 3);
    run(tbl[0], 2, 1);
    // Timeout: no rvalid after grant
    bus.in_valid = 1'b1;
    bus.func3    = 3'b010;
    bus.addr     = 32'h8000_0020;
    bus.rd       = 5'd21;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 32'd6);
    sb.push_back('{32'h0, 5'd21, 1'b1});
    bus.out_ready = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    chk("stray_rvalid_ignored", {31'd0, bus.out_valid}, 32'd0);
    chk("stray_in_ready", {31'd0, bus.in_ready}, 32'd1);
    // Reset while waiting for data
    bus.in_valid = 1'b1;
    bus.func3    = 3'b010;
    bus.addr     = 32'h8000_0010;
    bus.rd       = 5'd17;
    tick();
    bus.in_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_mem_addr", bus.mem_addr, 32'd0);
    chk("arst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_fault", {31'd0, bus.out_fault}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("old_rvalid_dropped", {31'd0, bus.out_valid}, 32'd0);
    run('{3'b010, 32'h8000_0040, 5'd30, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1}, 1, 0);
    tick();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
